// File: rtl/vga_frame_packer_pkg.sv
// Shared types and constants for the VGA frame packer.
// FSM state encoding, pack width and default frame geometry.
package vga_frame_packer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACKLOW,
    CAPTURE,
    FLUSH,
    DACK,
    REPORT
  } state_t;

  localparam int PIX_PER_WORD = 4;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int DEF_FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

endpackage

// File: rtl/vga_frame_packer_pack4.sv
// Byte-lane packer: four 8-bit pixels into one 32-bit word.
// Ports: i_clear/i_en/i_data in; o_word (word incl. current byte),
// o_wrap (fourth byte this cycle), o_idx, o_partial (zero-padded).
module pixel_pack4
  import vga_frame_packer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word,
  output logic        o_wrap,
  output logic [1:0]  o_idx,
  output logic [31:0] o_partial
);

  logic [31:0] r_pack;
  logic [1:0]  r_idx;
  logic [31:0] w_word;

  // Word as it looks with the incoming byte merged in.
  always_comb begin
    w_word = r_pack;
    w_word[{r_idx, 3'b000} +: 8] = i_data;
  end

  assign o_word    = w_word;
  assign o_wrap    = i_en && (r_idx == 2'(PIX_PER_WORD - 1));
  assign o_idx     = r_idx;
  assign o_partial = r_pack;

  // Pack register is zeroed on wrap so a later partial
  // word comes out zero-padded.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pack <= '0;
      r_idx  <= '0;
    end else if (i_clear) begin
      r_pack <= '0;
      r_idx  <= '0;
    end else if (i_en) begin
      if (o_wrap) begin
        r_pack <= '0;
        r_idx  <= '0;
      end else begin
        r_pack <= w_word;
        r_idx  <= r_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/vga_frame_packer.sv
// One-frame capture controller and 8->32 bit pixel packer.
// Ports: arm/busy host side; vga_* capture handshake; video in;
// word/word_valid/word_ready/word_last out; frame status outputs.
module vga_frame_packer
  import vga_frame_packer_pkg::*;
#(
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int COUNT_W      = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               arm,
  output logic               busy,
  output logic               vga_start,
  input  logic               vga_start_ack,
  input  logic               vga_done,
  output logic               vga_done_ack,
  input  logic [7:0]         video,
  input  logic               video_valid,
  output logic [31:0]        word,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               word_last,
  output logic               frame_done,
  output logic [COUNT_W-1:0] pixel_count,
  output logic               overflow,
  output logic               short_frame
);

  localparam logic [COUNT_W-1:0] LP_FULL = COUNT_W'(FRAME_PIXELS);
  localparam logic [COUNT_W-1:0] LP_LAST = COUNT_W'(FRAME_PIXELS - 1);

  state_t             r_state;
  logic               r_start;
  logic               r_done_ack;
  logic               r_frame_done;
  logic [31:0]        r_word;
  logic               r_valid;
  logic               r_last;
  logic [COUNT_W-1:0] r_count;
  logic               r_ovf;
  logic               r_short;

  logic        w_in_cap;
  logic        w_take;
  logic        w_room;
  logic        w_emit;
  logic        w_clear;
  logic        w_wrap;
  logic [31:0] w_word;
  logic [31:0] w_partial;
  logic [1:0]  w_idx;

  // Pixels are honoured from ACKLOW on; anything past a full
  // frame is discarded.
  assign w_in_cap = (r_state == ACKLOW) || (r_state == CAPTURE);
  assign w_take   = w_in_cap && video_valid && (r_count < LP_FULL);
  // Holding register can take a word this cycle.
  assign w_room   = !r_valid || word_ready;
  assign w_emit   = (r_state == FLUSH) && (w_idx != 2'd0) && w_room;
  assign w_clear  = ((r_state == IDLE) && arm) || w_emit;

  pixel_pack4 u_pack (
    .i_clk     (clock),
    .i_rst_n   (reset),
    .i_clear   (w_clear),
    .i_en      (w_take),
    .i_data    (video),
    .o_word    (w_word),
    .o_wrap    (w_wrap),
    .o_idx     (w_idx),
    .o_partial (w_partial)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_start      <= 1'b0;
      r_done_ack   <= 1'b0;
      r_frame_done <= 1'b0;
      r_word       <= '0;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_short      <= 1'b0;
    end else begin
      if (r_valid && word_ready)
        r_valid <= 1'b0;

      if (w_take)
        r_count <= r_count + 1'b1;

      // Completed word: load over a handshaking word or drop it.
      if (w_wrap) begin
        if (w_room) begin
          r_word  <= w_word;
          r_valid <= 1'b1;
          r_last  <= (r_count == LP_LAST);
        end else begin
          r_ovf <= 1'b1;
        end
      end

      unique case (r_state)
        IDLE: begin
          if (arm) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_short <= 1'b0;
            r_start <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (vga_start_ack) begin
            r_start <= 1'b0;
            r_state <= ACKLOW;
          end
        end
        ACKLOW: begin
          if (!vga_start_ack)
            r_state <= CAPTURE;
        end
        CAPTURE: begin
          if (vga_done)
            r_state <= FLUSH;
        end
        FLUSH: begin
          if (w_idx != 2'd0) begin
            r_short <= 1'b1;
            if (w_room) begin
              r_word  <= w_partial;
              r_valid <= 1'b1;
              r_last  <= 1'b1;
            end
          end else begin
            if (r_count < LP_FULL)
              r_short <= 1'b1;
            if (!r_valid) begin
              r_done_ack <= 1'b1;
              r_state    <= DACK;
            end
          end
        end
        DACK: begin
          if (!vga_done) begin
            r_done_ack   <= 1'b0;
            r_frame_done <= 1'b1;
            r_state      <= REPORT;
          end
        end
        REPORT: begin
          r_frame_done <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy         = (r_state != IDLE);
  assign vga_start    = r_start;
  assign vga_done_ack = r_done_ack;
  assign word         = r_word;
  assign word_valid   = r_valid;
  assign word_last    = r_last;
  assign frame_done   = r_frame_done;
  assign pixel_count  = r_count;
  assign overflow     = r_ovf;
  assign short_frame  = r_short;

endmodule

// File: tb/tb_vga_frame_packer.sv
// Self-checking bench for vga_frame_packer (FRAME_PIXELS=8).
// Table of frames plus hand sequences; words checked by scoreboard.
module tb_vga_frame_packer;

  localparam int FP = 8;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          arm = 1'b0;
  logic          vga_start_ack = 1'b0;
  logic          vga_done = 1'b0;
  logic [7:0]    video = '0;
  logic          video_valid = 1'b0;
  logic          word_ready = 1'b1;
  logic          busy;
  logic          vga_start;
  logic          vga_done_ack;
  logic [31:0]   word;
  logic          word_valid;
  logic          word_last;
  logic          frame_done;
  logic [CW-1:0] pixel_count;
  logic          overflow;
  logic          short_frame;

  vga_frame_packer #(.FRAME_PIXELS(FP), .COUNT_W(CW)) dut (
    .clock         (clock),
    .reset         (reset),
    .arm           (arm),
    .busy          (busy),
    .vga_start     (vga_start),
    .vga_start_ack (vga_start_ack),
    .vga_done      (vga_done),
    .vga_done_ack  (vga_done_ack),
    .video         (video),
    .video_valid   (video_valid),
    .word          (word),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .word_last     (word_last),
    .frame_done    (frame_done),
    .pixel_count   (pixel_count),
    .overflow      (overflow),
    .short_frame   (short_frame)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int n_fd = 0;
  logic [32:0] exp_q[$];
  logic [32:0] e;
  logic        p_valid = 1'b0;
  logic        p_ready = 1'b0;
  logic        p_last = 1'b0;
  logic [31:0] p_word = '0;

  typedef struct {
    int          npix;
    logic [7:0]  base;
    int          st;
    int          sl;
    int          nw;
    logic [31:0] w0;
    logic        l0;
    logic [31:0] w1;
    logic        l1;
    int          cnt;
    logic        ovf;
    logic        shrt;
    string       name;
  } vec_t;

  vec_t vecs[6];

  // Output monitor: scoreboard pops and hold-stability checks.
  always @(negedge clock) begin
    if (reset && p_valid && !p_ready) begin
      total++;
      if (!word_valid || word !== p_word || word_last !== p_last) begin
        bad++;
        $display("FAIL hold: got v=%b w=%h l=%b want v=1 w=%h l=%b",
                 word_valid, word, word_last, p_word, p_last);
      end
    end
    if (reset && word_valid && word_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_word: got %h want none", word);
      end else begin
        e = exp_q.pop_front();
        if ({word_last, word} !== e) begin
          bad++;
          $display("FAIL word: got %h last=%b want %h last=%b",
                   word, word_last, e[31:0], e[32]);
        end
      end
    end
    if (frame_done) n_fd++;
    p_valid = word_valid;
    p_ready = word_ready;
    p_word  = word;
    p_last  = word_last;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic arm_start(input int hold);
    int k;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    k = 0;
    while (!vga_start && k < 10) begin
      tick();
      k++;
    end
    check("start_req", 32'(vga_start), 32'd1);
    vga_start_ack = 1'b1;
    repeat (hold) tick();
    vga_start_ack = 1'b0;
    tick();
  endtask

  task automatic pixels(input int n, input logic [7:0] base,
                        input int st, input int sl);
    int len;
    len = (st + sl > n) ? st + sl : n;
    for (int c = 0; c < len; c++) begin
      video_valid = (c < n);
      video       = base + 8'(c);
      word_ready  = !(c >= st && c < st + sl);
      tick();
    end
    video_valid = 1'b0;
    video       = '0;
    word_ready  = 1'b1;
  endtask

  task automatic finish_frame();
    int k;
    vga_done = 1'b1;
    tick();
    k = 0;
    while (!vga_done_ack && k < 30) begin
      tick();
      k++;
    end
    check("done_ack_rise", 32'(vga_done_ack), 32'd1);
    vga_done = 1'b0;
    k = 0;
    while (n_fd < 1 && k < 10) begin
      tick();
      k++;
    end
    tick();
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    if (v.nw > 0) exp_q.push_back({v.l0, v.w0});
    if (v.nw > 1) exp_q.push_back({v.l1, v.w1});
    n_fd = 0;
    arm_start(2);
    pixels(v.npix, v.base, v.st, v.sl);
    finish_frame();
    check({v.name, "_count"}, 32'(pixel_count), 32'(v.cnt));
    check({v.name, "_ovf"}, 32'(overflow), 32'(v.ovf));
    check({v.name, "_short"}, 32'(short_frame), 32'(v.shrt));
    check({v.name, "_fdone"}, 32'(n_fd), 32'd1);
    check({v.name, "_idle"}, 32'(busy), 32'd0);
    check({v.name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8, 8'h01, -1, 0, 2, 32'h04030201, 1'b0,
                32'h08070605, 1'b1, 8, 1'b0, 1'b0, "normal"};
    vecs[1] = '{6, 8'h01, -1, 0, 2, 32'h04030201, 1'b0,
                32'h00000605, 1'b1, 6, 1'b0, 1'b1, "short6"};
    vecs[2] = '{8, 8'h11, 3, 6, 1, 32'h14131211, 1'b0,
                32'h0, 1'b0, 8, 1'b1, 1'b0, "bpress"};
    vecs[3] = '{10, 8'h21, -1, 0, 2, 32'h24232221, 1'b0,
                32'h28272625, 1'b1, 8, 1'b0, 1'b0, "sat"};
    vecs[4] = '{3, 8'hA0, -1, 0, 1, 32'h00A2A1A0, 1'b1,
                32'h0, 1'b0, 3, 1'b0, 1'b1, "short3"};
    vecs[5] = '{4, 8'h50, -1, 0, 1, 32'h53525150, 1'b0,
                32'h0, 1'b0, 4, 1'b0, 1'b1, "short4"};

    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(vga_start), 32'd0);
    check("rst_dack", 32'(vga_done_ack), 32'd0);
    check("rst_wvalid", 32'(word_valid), 32'd0);
    check("rst_wlast", 32'(word_last), 32'd0);
    check("rst_fdone", 32'(frame_done), 32'd0);
    check("rst_count", 32'(pixel_count), 32'd0);
    check("rst_word", word, 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_short", 32'(short_frame), 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Start/done handshake ordering.
    exp_q.push_back({1'b0, 32'h34333231});
    exp_q.push_back({1'b1, 32'h38373635});
    n_fd = 0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("hs_start_hi", 32'(vga_start), 32'd1);
    vga_start_ack = 1'b1;
    tick();
    check("hs_start_drop", 32'(vga_start), 32'd0);
    tick();
    vga_done = 1'b1;
    tick();
    tick();
    vga_done = 1'b0;
    check("hs_no_cap_acklow", 32'(vga_done_ack), 32'd0);
    check("hs_busy", 32'(busy), 32'd1);
    tick();
    vga_start_ack = 1'b0;
    tick();
    pixels(8, 8'h31, -1, 0);
    vga_done = 1'b1;
    for (int k = 0; k < 30 && !vga_done_ack; k++) tick();
    check("hs_dack_rise", 32'(vga_done_ack), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hs_dack_hold", 32'(vga_done_ack), 32'd1);
    end
    vga_done = 1'b0;
    tick();
    check("hs_dack_drop", 32'(vga_done_ack), 32'd0);
    for (int k = 0; k < 10 && n_fd < 1; k++) tick();
    tick();
    check("hs_count", 32'(pixel_count), 32'd8);
    check("hs_fdone", 32'(n_fd), 32'd1);
    check("hs_drain", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a frame.
    n_fd = 0;
    arm_start(2);
    pixels(3, 8'h41, -1, 0);
    reset = 1'b0;
    tick();
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_start", 32'(vga_start), 32'd0);
    check("mid_dack", 32'(vga_done_ack), 32'd0);
    check("mid_wvalid", 32'(word_valid), 32'd0);
    check("mid_wlast", 32'(word_last), 32'd0);
    check("mid_count", 32'(pixel_count), 32'd0);
    check("mid_word", word, 32'd0);
    check("mid_ovf", 32'(overflow), 32'd0);
    check("mid_short", 32'(short_frame), 32'd0);
    reset = 1'b1;
    repeat (4) tick();
    check("mid_no_fdone", 32'(n_fd), 32'd0);
    check("mid_no_word", 32'(word_valid), 32'd0);
    run_vec('{8, 8'h61, -1, 0, 2, 32'h64636261, 1'b0,
              32'h68676665, 1'b1, 8, 1'b0, 1'b0, "clean"});

    // Arm pulse during CAPTURE must be ignored.
    exp_q.push_back({1'b0, 32'h74737271});
    n_fd = 0;
    arm_start(2);
    pixels(8, 8'h71, 3, 6);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("ab_busy", 32'(busy), 32'd1);
    check("ab_ovf_kept", 32'(overflow), 32'd1);
    finish_frame();
    tick();
    tick();
    check("ab_count", 32'(pixel_count), 32'd8);
    check("ab_ovf", 32'(overflow), 32'd1);
    check("ab_short", 32'(short_frame), 32'd0);
    check("ab_fdone", 32'(n_fd), 32'd1);
    check("ab_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
